dtmf_tone_gen: RTL and testbench
================================

Name: dtmf_tone_gen

Overview:
DTMF tone generator, the transmit-side counterpart of the control module's bin-to-tone lookup. It accepts a 16-bit tone code in the same encoding the decoder emits (0-9, A-D = 10-13, * = 14, # = 15, 16'hFFFF = no tone). It synthesises the matching row+column sinusoid pair as a signed PCM sample stream at 8 kHz, for a fixed tone duration followed by a silent inter-digit gap. It feeds the DAC/loopback path so the receive chain can be exercised end-to-end.

Parameters:
SAMPLE_DIV, 6250, clock cycles per output sample (50 MHz / 8 kHz); minimum value 2
TONE_SAMPLES, 800, samples of tone per digit (100 ms)
GAP_SAMPLES, 400, samples of silence after each digit (50 ms)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  request to send one digit; sampled only in IDLE
tone  in  16  tone code, latched on an accepted start
busy  out  1  high from the accepted start through the final gap sample
done  out  1  one-cycle pulse when the digit, including its gap, completes
error  out  1  one-cycle pulse when start is rejected (tone > 15)
sample  out  12  signed two's-complement PCM sample
sample_valid  out  1  one-cycle strobe per sample

Behaviour:
- Reset (synchronous, active-high): state = IDLE; busy, done, error, sample_valid = 0; sample = 0; phase accumulators, tick counter and sample counter = 0. A reset mid-digit aborts the digit with no done pulse.
- Keypad map:
  - Rows: row 0 = {1,2,3,A}, row 1 = {4,5,6,B}, row 2 = {7,8,9,C}, row 3 = {*,0,#,D}.
  - Column index is the position within the row.
- Row phase increments (16-bit accumulator, 8 kHz): 697 Hz = 5710, 770 Hz = 6308, 852 Hz = 6980, 941 Hz = 7709.
- Column phase increments: 1209 Hz = 9904, 1336 Hz = 10945, 1477 Hz = 12100, 1633 Hz = 13378.
- Sine function: S(p) = round(1023 * sin(2*pi*p/256)), where p = accumulator[15:8]. A full or quarter-wave table is permitted; results must be bit-exact.
- Sample arithmetic: sample = S(p_lo) + S(p_hi), sign-extended to 12 bits. Range is -2046..2046, so saturation is never needed.
- FSM states: IDLE, TONE, GAP.
- IDLE, start = 1, tone <= 15:
  - Latch both increments; zero both accumulators, the tick counter and the sample counter.
  - busy <= 1; state -> TONE.
- IDLE, start = 1, tone > 15 (including 16'hFFFF): error <= 1 for one cycle; stay in IDLE; busy stays 0; no done.
- Tick counter: counts 0..SAMPLE_DIV-1. A tick occurs when it equals SAMPLE_DIV-1, so the first tick is SAMPLE_DIV cycles after the accepting edge.
- TONE, on each tick:
  - Register sample = S(p_lo) + S(p_hi) from the current accumulators; sample_valid <= 1.
  - Then add the increments to the accumulators (wrap-around modulo 2^16).
  - After sample TONE_SAMPLES, clear the sample counter; state -> GAP.
- GAP, on each tick: sample <= 0; sample_valid <= 1.
- GAP, on tick number GAP_SAMPLES, in the same edge: done <= 1, busy <= 0, state -> IDLE. This means done coincides with the final sample_valid.
- A start the cycle after done is accepted; back-to-back digits are legal.
- start while busy is ignored and tone is not re-latched; changes on the tone input while busy have no effect.
- sample holds its last value between strobes and returns to 0 in IDLE after the gap.
- Total duration: accepting edge to done = (TONE_SAMPLES + GAP_SAMPLES) * SAMPLE_DIV cycles.

Test Plan:
1. Reset, then idle 20 cycles -> busy, done, error, sample_valid = 0; sample = 0.
2. SAMPLE_DIV=4, TONE_SAMPLES=8, GAP_SAMPLES=4; start with tone=5:
   - Strobes occur at cycles 4, 8, ..., 48 after acceptance.
   - Sample 1 = 0; sample 2 = 568 + 877 = 1445.
   - Samples 9-12 = 0; done is high at cycle 48 only.
   - busy is high for cycles 1-47.
3. start with tone=16'hFFFF, then tone=16 -> error pulses one cycle each; busy never rises; no sample_valid strobes.
4. Re-assert start with tone=1 mid-digit of tone=13 -> ignored. Samples match tone 13 (941 + 1633 Hz, increments 7709/13378). Exactly one done pulse.
5. Assert reset at sample 5 of a digit -> the next cycle shows the idle values; no done pulse. A new start then produces a first sample of 0.
6. Loop tone codes 0-15, each started the cycle after the previous done -> every digit's second sample equals S(inc_lo>>8) + S(inc_hi>>8) per the keypad map.

Source files
------------

// File: rtl/dtmf_tone_gen.sv
// dtmf_tone_gen: DTMF row+column sinusoid pair synthesiser.
// Emits one signed 12-bit PCM sample per SAMPLE_DIV clocks, then a silent gap.
`default_nettype none

module dtmf_tone_gen #(
    parameter int SAMPLE_DIV   = 6250,
    parameter int TONE_SAMPLES = 800,
    parameter int GAP_SAMPLES  = 400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] tone,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] sample,
    output logic        sample_valid
);

    localparam int TW   = $clog2(SAMPLE_DIV);
    localparam int SMAX = (TONE_SAMPLES > GAP_SAMPLES) ? TONE_SAMPLES : GAP_SAMPLES;
    localparam int SW   = $clog2(SMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] TONE_LAST = SW'(TONE_SAMPLES - 1);
    localparam logic [SW-1:0] GAP_LAST  = SW'(GAP_SAMPLES - 1);

    // round(1023*sin(2*pi*k/256)) for k = 0..63; k = 64 is the 1023 peak.
    localparam logic [9:0] QTAB [64] = '{
        10'd0,   10'd25,  10'd50,  10'd75,  10'd100, 10'd125, 10'd150, 10'd175,
        10'd200, 10'd224, 10'd249, 10'd273, 10'd297, 10'd321, 10'd345, 10'd368,
        10'd391, 10'd415, 10'd437, 10'd460, 10'd482, 10'd504, 10'd526, 10'd547,
        10'd568, 10'd589, 10'd609, 10'd629, 10'd649, 10'd668, 10'd687, 10'd705,
        10'd723, 10'd741, 10'd758, 10'd775, 10'd791, 10'd806, 10'd822, 10'd836,
        10'd851, 10'd864, 10'd877, 10'd890, 10'd902, 10'd914, 10'd925, 10'd935,
        10'd945, 10'd954, 10'd963, 10'd971, 10'd979, 10'd986, 10'd992, 10'd998,
        10'd1003, 10'd1008, 10'd1012, 10'd1015, 10'd1018, 10'd1020, 10'd1022, 10'd1023
    };

    localparam logic [15:0] ROW_INC [4] = '{16'd5710, 16'd6308, 16'd6980, 16'd7709};
    localparam logic [15:0] COL_INC [4] = '{16'd9904, 16'd10945, 16'd12100, 16'd13378};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic signed [10:0] sine(input logic [7:0] p);
        logic [9:0] mag;
        if (p[6])
            mag = (p[5:0] == 6'd0) ? 10'd1023 : QTAB[6'd0 - p[5:0]];
        else
            mag = QTAB[p[5:0]];
        return p[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    function automatic logic [1:0] key_row(input logic [3:0] k);
        case (k)
            4'd1, 4'd2, 4'd3, 4'd10:  return 2'd0;
            4'd4, 4'd5, 4'd6, 4'd11:  return 2'd1;
            4'd7, 4'd8, 4'd9, 4'd12:  return 2'd2;
            default:                  return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] k);
        case (k)
            4'd1, 4'd4, 4'd7, 4'd14:  return 2'd0;
            4'd2, 4'd5, 4'd8, 4'd0:   return 2'd1;
            4'd3, 4'd6, 4'd9, 4'd15:  return 2'd2;
            default:                  return 2'd3;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           valid_q, valid_d;
    logic [11:0]    sample_q, sample_d;
    logic [15:0]    inc_lo_q, inc_lo_d, inc_hi_q, inc_hi_d;
    logic [15:0]    acc_lo_q, acc_lo_d, acc_hi_q, acc_hi_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [SW-1:0]  cnt_q, cnt_d;

    logic                w_tick;
    logic signed [10:0]  w_s_lo, w_s_hi;
    logic [11:0]         w_sum;

    assign w_tick = (tick_q == TICK_LAST);
    assign w_s_lo = sine(acc_lo_q[15:8]);
    assign w_s_hi = sine(acc_hi_q[15:8]);
    assign w_sum  = {w_s_lo[10], w_s_lo} + {w_s_hi[10], w_s_hi};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            inc_lo_q <= '0;
            inc_hi_q <= '0;
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            tick_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            inc_lo_q <= inc_lo_d;
            inc_hi_q <= inc_hi_d;
            acc_lo_q <= acc_lo_d;
            acc_hi_q <= acc_hi_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        valid_d  = 1'b0;
        sample_d = sample_q;
        inc_lo_d = inc_lo_q;
        inc_hi_d = inc_hi_q;
        acc_lo_d = acc_lo_q;
        acc_hi_d = acc_hi_q;
        tick_d   = tick_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                sample_d = '0;
                if (start) begin
                    if (tone <= 16'd15) begin
                        inc_lo_d = ROW_INC[key_row(tone[3:0])];
                        inc_hi_d = COL_INC[key_col(tone[3:0])];
                        acc_lo_d = '0;
                        acc_hi_d = '0;
                        tick_d   = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = TONE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            TONE: begin
                tick_d = w_tick ? '0 : tick_q + 1'b1;
                if (w_tick) begin
                    // Sample uses the phase before this tick's increment.
                    sample_d = w_sum;
                    valid_d  = 1'b1;
                    acc_lo_d = acc_lo_q + inc_lo_q;
                    acc_hi_d = acc_hi_q + inc_hi_q;
                    if (cnt_q == TONE_LAST) begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                tick_d = w_tick ? '0 : tick_q + 1'b1;
                if (w_tick) begin
                    sample_d = '0;
                    valid_d  = 1'b1;
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dtmf_tone_gen.sv
// tb_dtmf_tone_gen: scoreboard bench for dtmf_tone_gen with shortened timing.
`default_nettype none
`timescale 1ns/1ps

module tb_dtmf_tone_gen;

    localparam int DIV = 4;
    localparam int TS  = 8;
    localparam int GS  = 4;
    localparam int DUR = (TS + GS) * DIV;

    localparam int KEYPAD  [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    localparam int ROW_REF [4]    = '{5710, 6308, 6980, 7709};
    localparam int COL_REF [4]    = '{9904, 10945, 12100, 13378};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tone  = 16'd0;
    logic        busy, done, error, sample_valid;
    logic [11:0] sample;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q [$];

    dtmf_tone_gen #(
        .SAMPLE_DIV  (DIV),
        .TONE_SAMPLES(TS),
        .GAP_SAMPLES (GS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .tone        (tone),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .sample      (sample),
        .sample_valid(sample_valid)
    );

    always #5 clock = ~clock;

    function automatic int s_ref(input int p);
        real x;
        x = 1023.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    function automatic int key_pos(input int code);
        int pos = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (KEYPAD[i][j] == code) pos = i * 4 + j;
        return pos;
    endfunction

    function automatic logic [11:0] second_sample(input int code);
        int pos = key_pos(code);
        return 12'(s_ref(ROW_REF[pos / 4] >> 8) + s_ref(COL_REF[pos % 4] >> 8));
    endfunction

    task automatic push_digit(input int code);
        int pos, lo, hi;
        pos = key_pos(code);
        lo = 0;
        hi = 0;
        for (int s = 0; s < TS; s++) begin
            exp_q.push_back(12'(s_ref(lo >> 8) + s_ref(hi >> 8)));
            lo = (lo + ROW_REF[pos / 4]) % 65536;
            hi = (hi + COL_REF[pos % 4]) % 65536;
        end
        repeat (GS) exp_q.push_back(12'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue_start(input logic [15:0] code);
        start = 1'b1;
        tone  = code;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            checks++;
            if ({busy, done, error, sample_valid, sample} !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got b%b d%b e%b v%b s%0d expected all 0",
                         n, busy, done, error, sample_valid, sample);
            end
        end
    endtask

    task automatic test_basic();
        int sidx = 0;
        logic [11:0] e;
        push_digit(5);
        issue_start(16'd5);
        for (int n = 0; n <= DUR; n++) begin
            if (n > 0) @(negedge clock);
            checks++;
            if (busy !== 1'(n < DUR)) begin
                errors++; $display("FAIL basic_busy cyc %0d got %b expected %b", n, busy, n < DUR);
            end
            checks++;
            if (done !== 1'(n == DUR)) begin
                errors++; $display("FAIL basic_done cyc %0d got %b expected %b", n, done, n == DUR);
            end
            checks++;
            if (sample_valid !== 1'(n > 0 && n % DIV == 0)) begin
                errors++; $display("FAIL basic_strobe cyc %0d got %b", n, sample_valid);
            end
            if (sample_valid) begin
                sidx++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hXXX;
                checks++;
                if (sample !== e) begin
                    errors++; $display("FAIL basic_sample #%0d got %0d expected %0d", sidx, $signed(sample), $signed(e));
                end
                if (sidx == 1 || sidx == 2) begin
                    checks++;
                    if (sample !== ((sidx == 1) ? 12'd0 : 12'd1445)) begin
                        errors++; $display("FAIL basic_known #%0d got %0d", sidx, $signed(sample));
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL basic_count got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_error();
        logic [15:0] codes [2] = '{16'hFFFF, 16'd16};
        for (int k = 0; k < 2; k++) begin
            issue_start(codes[k]);
            checks++;
            if ({error, busy, sample_valid, done} !== 4'b1000) begin
                errors++; $display("FAIL error_pulse code %h got e%b b%b v%b d%b expected 1000",
                                   codes[k], error, busy, sample_valid, done);
            end
            for (int n = 0; n < 8; n++) begin
                @(negedge clock);
                checks++;
                if ({error, busy, sample_valid, done} !== 4'b0000) begin
                    errors++; $display("FAIL error_after code %h cyc %0d got e%b b%b v%b d%b expected 0000",
                                       codes[k], n, error, busy, sample_valid, done);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [11:0] e;
        push_digit(13);
        issue_start(16'd13);
        for (int n = 0; n <= DUR + 8; n++) begin
            if (n > 0) @(negedge clock);
            if (n == 10) begin start = 1'b1; tone = 16'd1; end
            if (n == 11) start = 1'b0;
            if (done) dones++;
            if (sample_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hXXX;
                checks++;
                if (sample !== e) begin
                    errors++; $display("FAIL ignore_sample cyc %0d got %0d expected %0d", n, $signed(sample), $signed(e));
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL ignore_dones got %0d expected 1", dones);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL ignore_count got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int sidx = 0;
        logic [11:0] e;
        push_digit(7);
        issue_start(16'd7);
        for (int n = 0; n <= 5 * DIV; n++) begin
            if (n > 0) @(negedge clock);
            if (sample_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hXXX;
                checks++;
                if (sample !== e) begin
                    errors++; $display("FAIL rstmid_sample cyc %0d got %0d expected %0d", n, $signed(sample), $signed(e));
                end
            end
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, error, sample_valid, sample} !== 16'd0) begin
            errors++; $display("FAIL rstmid_idle got b%b d%b e%b v%b s%0d expected all 0",
                               busy, done, error, sample_valid, sample);
        end
        reset = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 2 * DIV; n++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rstmid_quiet cyc %0d got d%b b%b expected 0 0", n, done, busy);
            end
        end
        push_digit(7);
        issue_start(16'd7);
        for (int n = 0; n <= DUR; n++) begin
            if (n > 0) @(negedge clock);
            if (sample_valid) begin
                sidx++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hXXX;
                checks++;
                if (sample !== e) begin
                    errors++; $display("FAIL rstmid_redo #%0d got %0d expected %0d", sidx, $signed(sample), $signed(e));
                end
                if (sidx == 1) begin
                    checks++;
                    if (sample !== 12'd0) begin
                        errors++; $display("FAIL rstmid_first got %0d expected 0", $signed(sample));
                    end
                end
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL rstmid_done got %b expected 1", done);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int sidx;
        logic [11:0] e;
        for (int code = 0; code < 16; code++) begin
            sidx = 0;
            push_digit(code);
            issue_start(16'(code));
            for (int n = 0; n <= DUR; n++) begin
                if (n > 0) @(negedge clock);
                if (sample_valid) begin
                    sidx++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hXXX;
                    checks++;
                    if (sample !== e) begin
                        errors++; $display("FAIL b2b_sample tone %0d #%0d got %0d expected %0d",
                                           code, sidx, $signed(sample), $signed(e));
                    end
                    if (sidx == 2) begin
                        checks++;
                        if (sample !== second_sample(code)) begin
                            errors++; $display("FAIL b2b_second tone %0d got %0d expected %0d",
                                               code, $signed(sample), $signed(second_sample(code)));
                        end
                    end
                end
            end
            checks++;
            if (done !== 1'b1) begin
                errors++; $display("FAIL b2b_done tone %0d got %b expected 1", code, done);
            end
            if (exp_q.size() != 0) exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
